// File: rtl/astro_clk_reset.sv
// rtl/astro_clk_reset.sv - clk_sys reset sequencer and Astrocade clock-enable generator
//
// Sits behind the 14.31818 MHz system PLL. Filters the PLL lock flag, holds the
// core in reset for HOLD_CYCLES after lock (or after a soft reset request), then
// runs a 4-bit phase counter that produces single-cycle enables on clk_sys.
//
// Ports:
//   clk_sys    in   system clock (PLL outclk_0)
//   rst_n      in   asynchronous active-low reset
//   pll_locked in   PLL lock flag, asynchronous, synchronised here
//   soft_rst   in   level core-reset request, synchronised here
//   turbo      in   CPU /4 select (only when ASTRO_TURBO_EN is defined)
//   sys_rst_n  out  core reset, active-low, high only in RUN
//   ce_pix     out  pixel enable, 1 in 2 cycles
//   ce_cpu     out  CPU enable, 1 in 8 cycles (1 in 4 with turbo)
//   ce_snd     out  sound enable, 1 in 16 cycles
//   running    out  high while in RUN
//
// Optional feature macro: ASTRO_TURBO_EN (adds the turbo input).

module astro_clk_reset #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILTER = 16,
  parameter int HOLD_CYCLES = 1024
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic pll_locked,
  input  logic soft_rst,
`ifdef ASTRO_TURBO_EN
  input  logic turbo,
`endif
  output logic sys_rst_n,
  output logic ce_pix,
  output logic ce_cpu,
  output logic ce_snd,
  output logic running
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_e;

  localparam logic [7:0]  FILT_LAST = 8'(LOCK_FILTER - 1);
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

  logic [1:0]             rel_q;
  logic [SYNC_STAGES-1:0] lk_sync_q;
  logic [SYNC_STAGES-1:0] sr_sync_q;
  logic                   lk_s;
  logic                   sr_s;
  logic                   rel;

  state_e      state_q, state_d;
  logic [7:0]  filt_q, filt_d;
  logic [15:0] hold_q, hold_d;
  logic [3:0]  phase_q, phase_d;
  logic        cpu_hit;

  logic run_q;
  logic ce_pix_q;
  logic ce_cpu_q;
  logic ce_snd_q;

`ifdef ASTRO_TURBO_EN
  logic turbo_q, turbo_d;
`endif

  assign lk_s = lk_sync_q[SYNC_STAGES-1];
  assign sr_s = sr_sync_q[SYNC_STAGES-1];
  // rst_n release is re-timed so the FSM never acts on the edge reset lifts.
  assign rel  = rel_q[1];

  always_comb begin
    state_d = state_q;
    filt_d  = filt_q;
    hold_d  = hold_q;
    phase_d = phase_q + 4'd1;

    // Lock loss wins over everything, including a pending soft reset.
    if (!rel || !lk_s) begin
      state_d = WAIT_LOCK;
      filt_d  = '0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (filt_q == FILT_LAST) begin
            state_d = HOLD;
            hold_d  = HOLD_LAST;
            filt_d  = '0;
          end else begin
            filt_d = filt_q + 8'd1;
          end
        end
        HOLD: begin
          if (sr_s) begin
            hold_d = HOLD_LAST;
          end else if (hold_q == 16'd0) begin
            state_d = RUN;
          end else begin
            hold_d = hold_q - 16'd1;
          end
        end
        RUN: begin
          if (sr_s) begin
            state_d = HOLD;
            hold_d  = HOLD_LAST;
          end
        end
        default: begin
          state_d = WAIT_LOCK;
          filt_d  = '0;
        end
      endcase
    end

    // Phase only advances inside RUN; every entry to RUN starts at phase 0.
    if (state_d != RUN || state_q != RUN) begin
      phase_d = '0;
    end

`ifdef ASTRO_TURBO_EN
    // Rate changes are only taken at the phase-15 boundary.
    turbo_d = turbo_q;
    if (state_d != RUN) begin
      turbo_d = 1'b0;
    end else if (state_q == RUN && phase_q == 4'hF) begin
      turbo_d = turbo;
    end
    cpu_hit = turbo_d ? (phase_d[1:0] == 2'b11) : (phase_d[2:0] == 3'b111);
`else
    cpu_hit = (phase_d[2:0] == 3'b111);
`endif
  end

  // Outputs are registered from next-state/next-phase so they line up with state_q.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      rel_q     <= '0;
      lk_sync_q <= '0;
      sr_sync_q <= '0;
      state_q   <= WAIT_LOCK;
      filt_q    <= '0;
      hold_q    <= '0;
      phase_q   <= '0;
      run_q     <= 1'b0;
      ce_pix_q  <= 1'b0;
      ce_cpu_q  <= 1'b0;
      ce_snd_q  <= 1'b0;
    end else begin
      rel_q     <= {rel_q[0], 1'b1};
      lk_sync_q <= {lk_sync_q[SYNC_STAGES-2:0], pll_locked};
      sr_sync_q <= {sr_sync_q[SYNC_STAGES-2:0], soft_rst};
      state_q   <= state_d;
      filt_q    <= filt_d;
      hold_q    <= hold_d;
      phase_q   <= phase_d;
      run_q     <= (state_d == RUN);
      ce_pix_q  <= (state_d == RUN) && phase_d[0];
      ce_cpu_q  <= (state_d == RUN) && cpu_hit;
      ce_snd_q  <= (state_d == RUN) && (phase_d == 4'hF);
    end
  end

`ifdef ASTRO_TURBO_EN
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      turbo_q <= 1'b0;
    end else begin
      turbo_q <= turbo_d;
    end
  end
`endif

  assign sys_rst_n = run_q;
  assign running   = run_q;
  assign ce_pix    = ce_pix_q;
  assign ce_cpu    = ce_cpu_q;
  assign ce_snd    = ce_snd_q;

endmodule

// File: tb/tb_astro_clk_reset.sv
// tb/tb_astro_clk_reset.sv - self-checking bench for astro_clk_reset

module tb_astro_clk_reset;

  localparam int SS = 2;
  localparam int LF = 16;
  localparam int HC = 1024;

  logic clk_sys = 1'b0;
  logic rst_n = 1'b0;
  logic pll_locked = 1'b0;
  logic soft_rst = 1'b0;
  logic turbo = 1'b0;
  logic sys_rst_n, ce_pix, ce_cpu, ce_snd, running;

  int checks = 0;
  int passes = 0;

  astro_clk_reset #(.SYNC_STAGES(SS), .LOCK_FILTER(LF), .HOLD_CYCLES(HC)) dut (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .soft_rst   (soft_rst),
`ifdef ASTRO_TURBO_EN
    .turbo      (turbo),
`endif
    .sys_rst_n  (sys_rst_n),
    .ce_pix     (ce_pix),
    .ce_cpu     (ce_cpu),
    .ce_snd     (ce_snd),
    .running    (running)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: synchronised inputs are the raw samples two edges late. The core is
  // running once lock has been continuously good for LF+HC cycles and no soft
  // reset has been seen for HC cycles; phase is cycles-in-run minus one.
  bit p_ok0, p_ok1, p_sr0, p_sr1;
  int s_ok = 0, z_sr = 0, run_len = 0;
  bit e_run, e_pix, e_cpu, e_snd;

  always @(posedge clk_sys) begin
    bit ok, sr;
    int ph;
    if (!rst_n) begin
      p_ok0 = 0; p_ok1 = 0; p_sr0 = 0; p_sr1 = 0;
      s_ok = 0; z_sr = 0; run_len = 0;
      e_run = 0; e_pix = 0; e_cpu = 0; e_snd = 0;
    end else begin
      ok = p_ok1;
      sr = p_sr1;
      p_ok1 = p_ok0; p_sr1 = p_sr0;
      p_ok0 = pll_locked; p_sr0 = soft_rst;
      s_ok = ok ? s_ok + 1 : 0;
      z_sr = sr ? 0 : z_sr + 1;
      e_run = (s_ok >= LF + HC) && (z_sr >= HC);
      run_len = e_run ? run_len + 1 : 0;
      ph = e_run ? (run_len - 1) % 16 : 0;
      e_pix = e_run && (ph % 2 == 1);
      e_cpu = e_run && (ph % 8 == 7);
      e_snd = e_run && (ph == 15);
    end
    #1;
    chk("sys_rst_n", int'(sys_rst_n), int'(e_run));
    chk("running", int'(running), int'(e_run));
    chk("ce_pix", int'(ce_pix), int'(e_pix));
    chk("ce_cpu", int'(ce_cpu), int'(e_cpu));
    chk("ce_snd", int'(ce_snd), int'(e_snd));
  end

  // Counts sampled cycles until sys_rst_n reaches lvl; returns limit on timeout.
  task automatic wait_sys(input logic lvl, input int limit, output int n);
    n = 0;
    do begin
      @(posedge clk_sys); #1;
      n++;
    end while (sys_rst_n !== lvl && n < limit);
  endtask

  initial begin
    int n, np, nc, ns, nb, fp, fc, fs;

    repeat (5) @(negedge clk_sys);
    chk("reset_sys_rst_n", int'(sys_rst_n), 0);
    chk("reset_running", int'(running), 0);
    chk("reset_ce_any", int'(ce_pix | ce_cpu | ce_snd), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_sys);
    pll_locked = 1'b1;
    wait_sys(1'b1, 3000, n);
    chk("lock_latency", n, 1042);

    // Enable cadence, indexed as RUN cycles with the rise cycle as 1.
    chk("rise_ce_pix", int'(ce_pix), 0);
    np = 0; nc = 0; ns = 0; nb = 0; fp = 0; fc = 0; fs = 0;
    for (int i = 2; i <= 161; i++) begin
      @(posedge clk_sys); #1;
      if (ce_pix) begin np++; if (fp == 0) fp = i; end
      if (ce_cpu) begin nc++; if (fc == 0) fc = i; end
      if (ce_snd) begin ns++; if (fs == 0) fs = i; end
      if (ce_cpu && ce_snd) nb++;
    end
    chk("first_ce_pix", fp, 2);
    chk("first_ce_cpu", fc, 8);
    chk("first_ce_snd", fs, 16);
    chk("count_ce_pix", np, 80);
    chk("count_ce_cpu", nc, 20);
    chk("count_ce_snd", ns, 10);
    chk("count_cpu_snd", nb, 10);

    // Lock loss in RUN, then relock.
    @(negedge clk_sys);
    pll_locked = 1'b0;
    wait_sys(1'b0, 10, n);
    chk("lock_loss_latency", n, 3);
    repeat (4) @(negedge clk_sys);
    pll_locked = 1'b1;
    wait_sys(1'b1, 3000, n);
    chk("relock_latency", n, 1042);

    // Lock chatter restarts the filter.
    @(negedge clk_sys);
    pll_locked = 1'b0;
    repeat (20) @(negedge clk_sys);
    pll_locked = 1'b1;
    repeat (10) @(negedge clk_sys);
    pll_locked = 1'b0;
    repeat (2) @(negedge clk_sys);
    pll_locked = 1'b1;
    wait_sys(1'b1, 3000, n);
    chk("chatter_latency", n, 1042);

    // One-cycle soft reset pulse in RUN.
    repeat (40) @(negedge clk_sys);
    soft_rst = 1'b1;
    @(negedge clk_sys);
    soft_rst = 1'b0;
    wait_sys(1'b0, 10, n);
    chk("soft_pulse_fall", n, 2);
    wait_sys(1'b1, 3000, n);
    chk("soft_pulse_low", n, 1024);
    n = 0;
    do begin @(posedge clk_sys); #1; n++; end while (!ce_pix && n < 20);
    chk("soft_phase_restart", n + 1, 2);

    // Soft reset held for 500 cycles.
    @(negedge clk_sys);
    repeat (20) @(negedge clk_sys);
    soft_rst = 1'b1;
    repeat (500) @(negedge clk_sys);
    chk("soft_held_low", int'(sys_rst_n), 0);
    soft_rst = 1'b0;
    wait_sys(1'b1, 3000, n);
    chk("soft_held_release", n, 1026);

    // Randomised episodes, checked every cycle by the model.
    for (int ep = 0; ep < 24; ep++) begin
      @(negedge clk_sys);
      case ($urandom_range(0, 4))
        0: begin
          pll_locked = 1'b0;
          repeat ($urandom_range(1, 4)) @(negedge clk_sys);
          pll_locked = 1'b1;
        end
        1: begin
          soft_rst = 1'b1;
          repeat ($urandom_range(1, 30)) @(negedge clk_sys);
          soft_rst = 1'b0;
        end
        2: begin
          rst_n = 1'b0;
          repeat ($urandom_range(1, 4)) @(negedge clk_sys);
          rst_n = 1'b1;
        end
        3: begin
          soft_rst = 1'b1;
          pll_locked = 1'b0;
          repeat ($urandom_range(1, 3)) @(negedge clk_sys);
          pll_locked = 1'b1;
          repeat ($urandom_range(1, 3)) @(negedge clk_sys);
          soft_rst = 1'b0;
        end
        default: ;
      endcase
      repeat ($urandom_range(0, 1300)) @(negedge clk_sys);
    end

    repeat (5) @(negedge clk_sys);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
